// File: rtl/mem_dcache.sv
// MEM-stage data-memory responder: direct-mapped, one-word-per-line,
// write-through cache in front of a req/ack backing RAM.
module mem_dcache #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        ram_hit1_o,
  output logic        ram_hit2_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_ack_i,
  input  logic [31:0] ram_rdata_i
);
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DONE, WR_REQ, WR_DONE} state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic              req_q, req_d, we_q, we_d, hit2_q, hit2_d;
  logic [29:0]       addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;

  logic              fill_en;
  logic [31:0]       fill_data, merged;
  logic [IDX_W-1:0]  in_idx, req_idx;
  logic [TAG_W-1:0]  in_tag, req_tag;
  logic              lookup_hit, req_line_hit, hit1;
  logic              addr_lsb_unused;

  assign addr_lsb_unused = ^mem_addr_i[1:0];

  assign in_idx  = mem_addr_i[2+IDX_W-1:2];
  assign in_tag  = mem_addr_i[31:2+IDX_W];
  assign req_idx = addr_q[IDX_W-1:0];
  assign req_tag = addr_q[29:IDX_W];

  assign lookup_hit   = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign req_line_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Hit path is purely combinational; only IDLE may answer a load in-cycle.
  assign hit1 = (state_q == IDLE) && mem_ce_i && !mem_we_i && lookup_hit;

  assign ram_hit1_o  = hit1;
  assign ram_hit2_o  = hit2_q;
  assign ram_req_o   = req_q;
  assign ram_we_o    = we_q;
  assign ram_addr_o  = {addr_q, 2'b00};
  assign ram_sel_o   = sel_q;
  assign ram_wdata_o = wdata_q;

  always_comb begin
    mem_data_o = '0;
    if (hit1)                    mem_data_o = data_q[in_idx];
    else if (state_q == RD_DONE) mem_data_o = rdata_q;
  end

  always_comb begin
    merged = data_q[req_idx];
    for (int unsigned b = 0; b < 4; b++)
      if (sel_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    req_d     = req_q;
    we_d      = we_q;
    hit2_d    = 1'b0;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    fill_en   = 1'b0;
    fill_data = ram_rdata_i;
    unique case (state_q)
      IDLE: begin
        if (mem_ce_i && (mem_we_i || !lookup_hit)) begin
          addr_d  = mem_addr_i[31:2];
          wdata_d = mem_data_i;
          req_d   = 1'b1;
          we_d    = mem_we_i;
          sel_d   = mem_we_i ? mem_sel_i : 4'b1111;
          state_d = mem_we_i ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ: begin
        if (ram_ack_i) begin
          fill_en = 1'b1;
          rdata_d = ram_rdata_i;
          req_d   = 1'b0;
          hit2_d  = 1'b1;
          state_d = RD_DONE;
        end
      end
      WR_REQ: begin
        if (ram_ack_i) begin
          // Merge into a resident line; allocate on miss only for full words.
          if (req_line_hit) begin
            fill_en   = 1'b1;
            fill_data = merged;
          end else if (sel_q == 4'b1111) begin
            fill_en   = 1'b1;
            fill_data = wdata_q;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          hit2_d  = 1'b1;
          state_d = WR_DONE;
        end
      end
      RD_DONE, WR_DONE: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
    if (fill_en) valid_d[req_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      hit2_q  <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      we_q    <= we_d;
      hit2_q  <= hit2_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[req_idx] <= fill_data;
      tag_q[req_idx]  <= req_tag;
    end
  end
endmodule

// File: tb/tb_mem_dcache.sv
// Directed self-checking bench for mem_dcache with a hand-driven backing RAM.
module tb_mem_dcache;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_o;
  logic        ram_hit1_o, ram_hit2_o, ram_req_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [3:0]  ram_sel_o;
  logic        ram_ack_i;
  logic [31:0] ram_rdata_i;

  int checks = 0;
  int errors = 0;

  mem_dcache #(.IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .ram_hit1_o(ram_hit1_o), .ram_hit2_o(ram_hit2_o), .ram_req_o(ram_req_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
    .ram_wdata_o(ram_wdata_o), .ram_ack_i(ram_ack_i), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load; on a miss the backing RAM acks on REQ cycle n with rd.
  task automatic do_load(input string tag, input logic [31:0] a, input bit exp_hit,
                         input int n, input logic [31:0] rd, input bit drop_ce);
    int reqcyc = 0;
    @(negedge clk);
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = a; mem_sel_i = 4'hf;
    #1;
    check({tag, ".hit1"}, 32'(ram_hit1_o), 32'(exp_hit));
    if (exp_hit) begin
      check({tag, ".hitdata"}, mem_data_o, rd);
      check({tag, ".noreq"}, 32'(ram_req_o), 32'd0);
      @(negedge clk);
      mem_ce_i = 1'b0;
      #1 check({tag, ".noreq_after"}, 32'(ram_req_o), 32'd0);
      return;
    end
    @(negedge clk);
    if (drop_ce) mem_ce_i = 1'b0;
    check({tag, ".raddr"}, ram_addr_o, {a[31:2], 2'b00});
    check({tag, ".rsel"}, 32'(ram_sel_o), 32'hf);
    check({tag, ".rwe"}, 32'(ram_we_o), 32'd0);
    for (int k = 0; k <= n; k++) begin
      if (ram_req_o) reqcyc++;
      check({tag, ".strobes_wait"}, 32'({ram_hit1_o, ram_hit2_o}), 32'd0);
      if (k == n) begin ram_ack_i = 1'b1; ram_rdata_i = rd; end
      @(negedge clk);
      ram_ack_i = 1'b0; ram_rdata_i = 32'hBAD0BAD0;
    end
    check({tag, ".reqcycles"}, 32'(reqcyc), 32'(n + 1));
    check({tag, ".hit2"}, 32'(ram_hit2_o), 32'd1);
    check({tag, ".hit1_in_done"}, 32'(ram_hit1_o), 32'd0);
    check({tag, ".data"}, mem_data_o, rd);
    check({tag, ".req_drop"}, 32'(ram_req_o), 32'd0);
    mem_ce_i = 1'b0;
    @(negedge clk);
    check({tag, ".hit2_once"}, 32'(ram_hit2_o), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input int n);
    int reqcyc = 0;
    @(negedge clk);
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = a; mem_sel_i = s; mem_data_i = d;
    #1 check({tag, ".hit1"}, 32'(ram_hit1_o), 32'd0);
    @(negedge clk);
    check({tag, ".waddr"}, ram_addr_o, {a[31:2], 2'b00});
    check({tag, ".wsel"}, 32'(ram_sel_o), 32'(s));
    check({tag, ".wdata"}, ram_wdata_o, d);
    check({tag, ".wwe"}, 32'(ram_we_o), 32'd1);
    for (int k = 0; k <= n; k++) begin
      if (ram_req_o) reqcyc++;
      if (k == n) ram_ack_i = 1'b1;
      @(negedge clk);
      ram_ack_i = 1'b0;
    end
    check({tag, ".reqcycles"}, 32'(reqcyc), 32'(n + 1));
    check({tag, ".hit2"}, 32'(ram_hit2_o), 32'd1);
    check({tag, ".data0"}, mem_data_o, 32'd0);
    check({tag, ".req_drop"}, 32'(ram_req_o), 32'd0);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    @(negedge clk);
    check({tag, ".hit2_once"}, 32'(ram_hit2_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
    mem_sel_i = '0; mem_data_i = '0; ram_ack_i = 1'b0; ram_rdata_i = '0;
    repeat (2) @(negedge clk);
    check("reset.outs", {ram_addr_o[29:0], ram_hit1_o, ram_hit2_o}, 32'd0);
    check("reset.req_we_sel", 32'({ram_req_o, ram_we_o, ram_sel_o}), 32'd0);
    check("reset.wdata", ram_wdata_o, 32'd0);
    check("reset.mdata", mem_data_o, 32'd0);
    rst = 1'b1;

    do_load("cold", 32'h100, 1'b0, 3, 32'hDEADBEEF, 1'b0);
    do_load("rehit", 32'h100, 1'b1, 0, 32'hDEADBEEF, 1'b0);
    do_store("st_merge", 32'h100, 4'b1100, 32'h12345678, 1);
    do_load("merged", 32'h100, 1'b1, 0, 32'h1234BEEF, 1'b0);
    do_store("st_part", 32'h200, 4'b0001, 32'hAAAAAAAA, 0);
    do_load("untouched", 32'h100, 1'b1, 0, 32'h1234BEEF, 1'b0);
    do_load("part_miss", 32'h200, 1'b0, 0, 32'h000000AA, 1'b0);
    do_store("st_full", 32'h300, 4'b1111, 32'hCAFEF00D, 2);
    do_load("full_hit", 32'h300, 1'b1, 0, 32'hCAFEF00D, 1'b0);
    do_load("conf_a", 32'h100, 1'b0, 1, 32'h11111111, 1'b0);
    do_load("conf_b", 32'h140, 1'b0, 0, 32'h22222222, 1'b0);
    do_load("conf_a2", 32'h100, 1'b0, 2, 32'h11111111, 1'b0);
    do_load("flush", 32'h108, 1'b0, 1, 32'h33333333, 1'b1);
    do_load("flush_hit", 32'h108, 1'b1, 0, 32'h33333333, 1'b0);

    // Reset asserted in the middle of a read request.
    @(negedge clk);
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h104; mem_sel_i = 4'hf;
    @(negedge clk);
    check("mid.req", 32'(ram_req_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid.req_drop", 32'(ram_req_o), 32'd0);
    check("mid.strobes", 32'({ram_hit1_o, ram_hit2_o, ram_we_o}), 32'd0);
    check("mid.addr", ram_addr_o, 32'd0);
    @(negedge clk);
    mem_ce_i = 1'b0; rst = 1'b1;
    ram_ack_i = 1'b1; ram_rdata_i = 32'h77777777;
    @(negedge clk);
    ram_ack_i = 1'b0;
    check("late_ack.idle", 32'({ram_req_o, ram_hit2_o}), 32'd0);
    @(negedge clk);
    check("late_ack.nohit2", 32'(ram_hit2_o), 32'd0);
    do_load("post_rst", 32'h100, 1'b0, 1, 32'h55555555, 1'b0);
    do_load("post_rst_108", 32'h108, 1'b0, 0, 32'h66666666, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_dcache.md
Name: mem_dcache

Overview:
- Responder end of the MEM-stage data-memory interface.
- Accepts word requests (ce/we/addr/sel/data) from the MEM stage and returns read data plus the two completion strobes the MEM stage stalls on: ram_hit1 (cache hit) and ram_hit2 (backing transaction complete).
- Implements a direct-mapped, one-word-per-line, write-through data cache in front of a slower backing RAM reached through a req/ack handshake.

Parameters:
- IDX_W, 4, index width; number of lines = 2**IDX_W (16 by default).
- TAG_W, 30-IDX_W, tag width = addr[31:2+IDX_W].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- mem_ce_i  in  1  request valid from the MEM stage.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  32  byte address; bits [1:0] are ignored.
- mem_sel_i  in  4  byte enables; bit i selects byte lane i.
- mem_data_i  in  32  store data.
- mem_data_o  out  32  load data, valid with ram_hit1_o or ram_hit2_o on a load.
- ram_hit1_o  out  1  load hit, combinational, same cycle as the request.
- ram_hit2_o  out  1  one-cycle completion pulse for a load miss or any store.
- ram_req_o  out  1  backing request, held until ack.
- ram_we_o  out  1  backing write.
- ram_addr_o  out  32  backing word address, bits [1:0] = 0.
- ram_sel_o  out  4  backing byte enables.
- ram_wdata_o  out  32  backing write data.
- ram_ack_i  in  1  backing completion, one-cycle pulse.
- ram_rdata_i  in  32  backing read data, valid with ram_ack_i.

Behaviour:
- Reset (rst=0, asynchronous):
  - All valid bits cleared; state = IDLE.
  - All outputs 0.
  - Any in-flight backing transaction is abandoned; ram_req_o drops immediately.
- Storage:
  - valid[2**IDX_W], tag[2**IDX_W][TAG_W], data[2**IDX_W][32].
  - index = addr[2+IDX_W-1:2].
- Request latching: in IDLE with mem_ce_i=1 and no hit, addr/sel/data/we are latched into request registers. All ram_* outputs are driven from these registers. The MEM stage holds its request stable while stalled; the block does not depend on that after latching.
- States: IDLE, RD_REQ, RD_DONE, WR_REQ, WR_DONE.
- IDLE:
  - ce=1, we=0, valid & tag match: ram_hit1_o=1 and mem_data_o = line data, in the same cycle (0-cycle latency). State is unchanged.
  - ce=1, we=0, miss: latch the request and go to RD_REQ.
  - ce=1, we=1: latch the request and go to WR_REQ. Stores always go through the backing RAM; ram_hit1_o is never asserted for a store.
  - ce=0: idle; all strobes 0.
- RD_REQ:
  - ram_req_o=1, ram_we_o=0, ram_sel_o=4'b1111.
  - On ram_ack_i: write line data = ram_rdata_i, set tag and valid, capture rdata into a data register, go to RD_DONE.
- RD_DONE:
  - ram_hit2_o=1 and mem_data_o = captured data for exactly one cycle, then IDLE.
  - ram_hit1_o is forced 0 in this state, so there is never a double response.
- WR_REQ:
  - ram_req_o=1, ram_we_o=1; sel and wdata come from the latched request.
  - On ram_ack_i:
    - Line valid with tag match: merge the enabled bytes into the line.
    - Line miss and sel=4'b1111: allocate (data, tag, valid).
    - Line miss with a partial sel: no allocation; the line is untouched.
  - Then go to WR_DONE.
- WR_DONE: ram_hit2_o=1 for one cycle (mem_data_o=0), then IDLE.
- Strobe exclusivity: ram_hit1_o and ram_hit2_o are never 1 in the same cycle.
- Backing handshake:
  - ram_req_o rises the cycle after acceptance and stays high through the ack cycle; it drops the cycle after ack.
  - ram_ack_i outside RD_REQ/WR_REQ is ignored.
  - Ack in the first REQ cycle is legal.
- Latency:
  - Read miss: hit2 arrives N+2 cycles after the request, where N = cycles from req rising to ack (N≥0).
  - Store: same N+2.
- Abandoned request: if mem_ce_i drops mid-transaction (pipeline flush), the transaction still completes, including the fill/merge and the hit2 pulse. The MEM stage ignores the pulse.
- Lines are never dirty (write-through), so eviction is a plain overwrite.

Test Plan:
- Cold load 0x00000100, backing acks 3 cycles after req with 0xDEADBEEF -> ram_req_o high 4 cycles with ram_addr_o=0x100, then ram_hit2_o pulses once with mem_data_o=0xDEADBEEF; ram_hit1_o stays 0 throughout.
- Repeat load 0x100 immediately after -> ram_hit1_o=1 in the same cycle with 0xDEADBEEF; ram_req_o stays 0.
- Store 0x100, sel=4'b1100, data 0x12345678 -> backing sees we=1, sel=1100; then one hit2 pulse. A following load 0x100 hits with 0x1234BEEF.
- Partial store sel=0001 to uncached 0x200, then load 0x200 -> load misses. Full-word store to 0x300, then load 0x300 -> hit1.
- Conflict: load 0x100 (fill), then load 0x140 (same index 0) -> 0x140 misses and refills. A subsequent load 0x100 misses again.
- Assert rst=0 during RD_REQ -> ram_req_o and all strobes drop immediately. After release, load 0x100 misses (valid cleared); a late ram_ack_i arriving while in IDLE is ignored.
